// File: rtl/pipe_addsub.sv
// pipe_addsub: STAGES-slice pipelined add/subtract with valid/ready flow.
// Ports: clk_i/rst_i (sync, active-high); valid_i/ready_o, a_i, b_i,
// sub_i, c_i in; valid_o/ready_i, re_o, c_o, ovf_o, zero_o out.
// Optional feature macro ADDSUB_SAT_EN adds sat_i (signed saturation).
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             c_i,
`ifdef ADDSUB_SAT_EN
  input  logic             sat_i,
`endif
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] re_o,
  output logic             c_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int NS = (STAGES > 0) ? STAGES : 1;
  localparam int SW = WIDTH / NS;
  localparam int L  = NS - 1;

  generate
    if (WIDTH < 2 || STAGES < 1 || (WIDTH % NS) != 0) begin : g_bad_cfg
      $error("pipe_addsub: illegal WIDTH/STAGES combination");
    end
  endgenerate

  function automatic logic [SW:0] slice_add(
    input logic [SW-1:0] x,
    input logic [SW-1:0] y,
    input logic          ci
  );
    return {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, ci};
  endfunction

  // Per-stage registers. Operand B is stored already conditioned
  // (inverted for subtract), so later stages are pure adders.
  logic [WIDTH-1:0] r_a [NS];
  logic [WIDTH-1:0] r_b [NS];
  logic [WIDTH-1:0] r_s [NS];
  logic             r_c [NS];
  logic             r_v [NS];

  logic [WIDTH-1:0] r_re;
  logic             r_co;
  logic             r_ovf;
  logic             r_zero;

  // Stage inputs and slice results.
  logic [WIDTH-1:0] w_a   [NS];
  logic [WIDTH-1:0] w_b   [NS];
  logic [WIDTH-1:0] w_s   [NS];
  logic [WIDTH-1:0] w_sn  [NS];
  logic             w_ci  [NS];
  logic             w_v   [NS];
  logic [SW:0]      w_sum [NS];

  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_adv;

`ifdef ADDSUB_SAT_EN
  logic r_sat [NS];
  logic w_sat [NS];
  logic w_clamp;
`endif

  always_comb begin
    w_a[0]  = a_i;
    w_b[0]  = sub_i ? ~b_i : b_i;
    // Subtract uses the inverted borrow as carry-in.
    w_ci[0] = c_i ^ sub_i;
    w_s[0]  = '0;
    w_v[0]  = valid_i;
`ifdef ADDSUB_SAT_EN
    w_sat[0] = sat_i;
`endif
    for (int k = 1; k < NS; k++) begin
      w_a[k]  = r_a[k-1];
      w_b[k]  = r_b[k-1];
      w_ci[k] = r_c[k-1];
      w_s[k]  = r_s[k-1];
      w_v[k]  = r_v[k-1];
`ifdef ADDSUB_SAT_EN
      w_sat[k] = r_sat[k-1];
`endif
    end
    for (int k = 0; k < NS; k++) begin
      w_sum[k] = slice_add(w_a[k][k*SW +: SW],
                           w_b[k][k*SW +: SW],
                           w_ci[k]);
      w_sn[k]  = w_s[k];
      w_sn[k][k*SW +: SW] = w_sum[k][SW-1:0];
    end
  end

  assign w_raw = w_sn[L];

  // Same-sign operands giving an opposite-sign sum is exactly
  // carry-into-MSB xor carry-out-of-MSB.
  assign w_ovf = (w_a[L][WIDTH-1] == w_b[L][WIDTH-1]) &&
                 (w_raw[WIDTH-1] != w_a[L][WIDTH-1]);

`ifdef ADDSUB_SAT_EN
  // On overflow the true sign is the common operand sign.
  assign w_clamp = w_sat[L] && w_ovf;
  assign w_res   = !w_clamp         ? w_raw :
                   w_a[L][WIDTH-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                      {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_res = w_raw;
`endif

  // Global stall: everything holds while the output is blocked.
  assign w_adv   = !(r_v[L] && !ready_i);
  assign ready_o = w_adv || rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NS; k++) begin
        r_v[k] <= 1'b0;
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
`ifdef ADDSUB_SAT_EN
        r_sat[k] <= 1'b0;
`endif
      end
      r_re   <= '0;
      r_co   <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < NS; k++) begin
        r_v[k] <= w_v[k];
        if (w_v[k]) begin
          r_a[k] <= w_a[k];
          r_b[k] <= w_b[k];
          r_s[k] <= w_sn[k];
          r_c[k] <= w_sum[k][SW];
`ifdef ADDSUB_SAT_EN
          r_sat[k] <= w_sat[k];
`endif
        end
      end
      if (w_v[L]) begin
        r_re   <= w_res;
        r_co   <= w_sum[L][SW];
        r_ovf  <= w_ovf;
        r_zero <= (w_res == '0);
      end
    end
  end

  assign valid_o = r_v[L];
  assign re_o    = r_re;
  assign c_o     = r_co;
  assign ovf_o   = r_ovf;
  assign zero_o  = r_zero;

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits, at least 2.
REQ-002 SHALL have parameter STAGES, default 2: number of pipeline slices, at least 1, with WIDTH % STAGES == 0. Any other value SHALL fail elaboration.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 valid_i  input  1  operand set present.
REQ-006 ready_o  output  1  block accepts operands this cycle.
REQ-007 a_i  input  WIDTH  operand A.
REQ-008 b_i  input  WIDTH  operand B.
REQ-009 sub_i  input  1  0 = add, 1 = subtract.
REQ-010 c_i  input  1  carry-in for add, borrow-in for subtract.
REQ-011 valid_o  output  1  result present.
REQ-012 ready_i  input  1  downstream accepts the result.
REQ-013 re_o  output  WIDTH  result.
REQ-014 c_o  output  1  raw carry out of the MSB (for subtract, 1 = no borrow).
REQ-015 ovf_o  output  1  signed two's-complement overflow.
REQ-016 zero_o  output  1  re_o == 0.

Function
REQ-017 Add SHALL compute the result as {c_o, re_o} = a + b + c_i.
REQ-018 Subtract SHALL compute {c_o, re_o} = a + ~b + ~c_i, which is a - b - c_i mod 2^WIDTH.
REQ-019 ovf_o SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-020 The datapath SHALL be split into STAGES slices of WIDTH/STAGES bits each.
- Slice k SHALL be added in pipeline stage k, using the carry registered from stage k-1.
- Operand slices not yet consumed SHALL be delayed alongside.
- Result slices already produced SHALL be delayed alongside.
REQ-021 A transfer in SHALL occur when valid_i && ready_o; a transfer out SHALL occur when valid_o && ready_i.
REQ-022 Latency SHALL be exactly STAGES cycles from accept to valid_o when not stalled. Throughput SHALL be one operation per cycle.
REQ-023 ready_o SHALL equal !(valid_o && !ready_i). When it is 0, every stage SHALL hold (global stall).
REQ-024 While valid_o && !ready_i, re_o, c_o, ovf_o and zero_o SHALL be held stable.
REQ-025 Results SHALL leave in acceptance order, with no loss or duplication.
REQ-026 Bubbles (valid_i low) SHALL propagate as invalid stages. Invalid stages SHALL never assert valid_o.
REQ-027 Each stage's valid bit SHALL advance whenever the pipeline is not stalled, including while the output is idle.
REQ-028 Boundary cases:
- a = b = all-ones with c_i = 1 SHALL give re_o all-ones and c_o = 1.
- Carry SHALL ripple correctly across every slice boundary.

Reset
REQ-029 When rst_i is high at a clock edge, all stage valid bits, valid_o, re_o, c_o, ovf_o and zero_o SHALL be 0 after that edge.
REQ-030 Operations in flight when rst_i asserts SHALL be discarded and never emitted.
REQ-031 ready_o SHALL be 1 during and immediately after reset.
REQ-032 Inputs SHALL be ignored in every cycle where rst_i is high.

Configuration
REQ-033 With macro ADDSUB_SAT_EN defined, the block SHALL have an extra port sat_i  input  1, sampled with the operands.
REQ-034 With ADDSUB_SAT_EN defined and sat_i = 1, a signed overflow SHALL clamp re_o:
- to 2^(WIDTH-1)-1 when the true result is positive;
- to -2^(WIDTH-1) when the true result is negative.
REQ-035 When clamping, c_o and ovf_o SHALL still report the raw (unclamped) values, and zero_o SHALL be computed on the clamped re_o.
REQ-036 With ADDSUB_SAT_EN undefined, the sat_i port and the clamp logic SHALL be absent and the result SHALL always wrap.

Verification (WIDTH=32, STAGES=2, ready_i=1 unless stated)
REQ-037 Add, a=0xFFFFFFFF, b=1, c_i=0 -> 2 cycles later: re_o=0x00000000, c_o=1, ovf_o=0, zero_o=1.
REQ-038 Add, a=0x7FFFFFFF, b=1 -> re_o=0x80000000, c_o=0, ovf_o=1. With ADDSUB_SAT_EN and sat_i=1 -> re_o=0x7FFFFFFF, ovf_o=1.
REQ-039 Subtract, a=5, b=7, c_i=0 -> re_o=0xFFFFFFFE, c_o=0, ovf_o=0, zero_o=0.
REQ-040 Stall test: 8 back-to-back operations with ready_i low in cycles 3-5.
- ready_o SHALL be low exactly while the output is stalled.
- All 8 results SHALL come out in order and unchanged while held.
REQ-041 Reset test: assert rst_i for 1 cycle with 2 operations in flight.
- Next cycle: valid_o=0 and all outputs 0.
- The dropped operations SHALL never appear.
- A new operation SHALL complete with latency 2.
REQ-042 Carry-boundary sweep: a=0x0000FFFF, b=1 -> re_o=0x00010000; randomised operands SHALL match a reference model for STAGES = 1, 2, 4.
